rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Hardware program loader: the writer side of the instruction-ROM interface that the core fetches from.
- Accepts a framed byte stream (from a UART RX or a debug bridge), packs the bytes into 32-bit little-endian words and writes them to ROM starting at word address 0.
- Holds the core in reset while loading and releases it on success, replacing simulation-only hex preload on FPGA builds.

Parameters:
- ADDR_W, 12, ROM word-address width; capacity DEPTH = 2**ADDR_W words.
- TIMEOUT_CYC, 1000000, maximum idle cycles between accepted bytes once a frame has started.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle pulse; begins a load
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle
- rom_we  out  1  ROM write strobe, one cycle per word
- rom_waddr  out  ADDR_W  ROM word address
- rom_wdata  out  32  ROM write data
- core_rst_n  out  1  core reset, active-low; 0 holds the core
- busy  out  1  a load is in progress
- done  out  1  last load completed successfully (level)
- err  out  1  last load failed (level)
- err_code  out  2  0 none, 1 timeout, 2 length overflow, 3 checksum

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0, including core_rst_n = 0 (core held in reset), rom_waddr = 0 and err_code = 0. State is IDLE.
- Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4N payload bytes, each word little-endian (first byte is bits 7:0).
- Handshake: a byte is accepted when rx_valid && rx_ready. rx_ready is 1 only in LEN_LO, LEN_HI, DATA and CHK, and is combinational from state only.
- State machine:
  - IDLE: start goes to LEN_LO; busy = 1; done, err and err_code clear; core_rst_n = 0.
  - LEN_LO: accept a byte, go to LEN_HI.
  - LEN_HI: accept a byte to complete N.
    - N > DEPTH goes to ERR, code 2.
    - N == 0 goes to CHK if the checksum feature is enabled, otherwise DONE.
    - Otherwise goes to DATA.
  - DATA: bytes pack via a 2-bit byte index.
    - On acceptance of the 4th byte, the next cycle has rom_we = 1, rom_wdata = the packed word and rom_waddr = the word index. Latency is 1 cycle from the 4th byte.
    - The word index increments after each write.
    - After word N-1 is written, go to CHK or DONE.
  - DONE: busy = 0, done = 1, core_rst_n = 1.
  - ERR: busy = 0, err = 1, core_rst_n stays 0.
- start in DONE or ERR restarts exactly as from IDLE; core_rst_n drops to 0 on the cycle after start. start while busy is ignored.
- Timeout:
  - The counter resets on each accepted byte and on entering LEN_LO.
  - It increments in rx_ready states.
  - Reaching TIMEOUT_CYC-1 goes to ERR, code 1.
  - If an accepted byte arrives on the same cycle as the timeout, the byte wins.
- N == DEPTH is legal and fills the ROM exactly; the address never wraps.
- rom_we is never asserted outside DATA.
- Asserting rst mid-load aborts immediately to reset values. A partially written ROM is not cleared.

Optional Feature:
- Macro: ROM_LOADER_CHECKSUM_EN.
- Defined: after the payload, CHK accepts one byte. It must equal the two's-complement negation of the 8-bit sum of all LEN and payload bytes (the total sum of all bytes ≡ 0 mod 256).
  - Match goes to DONE.
  - Mismatch goes to ERR, code 3; the ROM writes already made remain.
- Undefined: the CHK state and sum register are absent; the payload end goes directly to DONE. err_code 3 never occurs.

Decomposition:
- Package rom_loader_pkg holds:
  - the state encoding (IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR);
  - the err_code constants (ERR_NONE, ERR_TIMEOUT, ERR_LEN, ERR_CSUM).
- Sub-module rom_word_packer: byte index counter plus a 32-bit shift/assemble register, emitting word_valid with the packed word. Clear input driven on entry to LEN_LO.
- The FSM, timeout counter and address counter stay in rom_loader.

Test Plan:
1. Reset, then start, then frame N = 2 with bytes 13 00 00 00, 93 00 10 00 (checksum appended when the macro is defined) -> rom_we pulses twice: addr 0 data 0x00000013, addr 1 data 0x00100093. Then done = 1, core_rst_n = 1, err = 0.
2. N = 0 frame -> no rom_we; done = 1 (after a checksum byte 0x00 when enabled).
3. With ADDR_W = 4, LEN = 0x0011 -> err = 1, err_code = 2, no rom_we, core_rst_n = 0. With LEN = 0x0010 and 64 bytes -> 16 writes, last at addr 15, done = 1.
4. TIMEOUT_CYC = 100, send 5 payload bytes of N = 2 then stall -> exactly 1 rom_we; err_code = 1 after 100 idle cycles. A byte arriving on cycle 99 prevents the error.
5. Macro on, frame N = 1 with a corrupted checksum byte -> err_code = 3, core_rst_n = 0. A following start plus a good frame -> done = 1, err = 0.
6. rx_valid held high with random gaps and rst pulsed mid-DATA -> outputs return to reset values asynchronously. start during busy has no effect.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared state encoding and error codes for the ROM program loader.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

endpackage

// File: rtl/rom_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid pulses the
// cycle after the fourth byte of each word.
module rom_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic        r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid && !i_clear && (r_idx == 2'd3);
      if (i_clear) begin
        r_idx  <= '0;
        r_word <= '0;
      end else if (i_valid) begin
        // Shifting right leaves the first byte of the word in bits 7:0.
        r_word <= {i_byte, r_word[31:8]};
        r_idx  <= r_idx + 2'd1;
      end
    end
  end

  assign o_word_valid = r_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/rom_loader.sv
// Framed byte-stream loader writing instruction ROM and gating core reset.
// Optional trailing checksum byte enabled by ROM_LOADER_CHECKSUM_EN.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = $clog2(TIMEOUT_CYC) + 1;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_err_code, w_code_nxt;
  logic [7:0]      r_len_lo;
  logic [ADDR_W:0] r_len, r_wcnt;
  logic [TW-1:0]   r_tmo;
  logic [16:0]     w_len_full;
  logic            w_accept, w_start, w_last_wr, w_tmo_hit;
  logic            w_word_valid;
  logic [31:0]     w_word;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]      r_sum;
  logic            w_csum_ok;
  assign w_csum_ok = ((r_sum + rx_data) == 8'd0);
`endif

  assign w_accept   = rx_valid && rx_ready;
  assign w_start    = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_len_full = {1'b0, rx_data, r_len_lo};
  assign w_last_wr  = w_word_valid && (r_wcnt == r_len - (ADDR_W+1)'(1));
  assign w_tmo_hit  = rx_ready && !w_accept && (r_tmo == TW'(TIMEOUT_CYC - 1));

  rom_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_start),
    .i_valid      (w_accept && (r_state == DATA) && !w_last_wr),
    .i_byte       (rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_err_code <= w_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_err_code;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (start) begin
          w_state_nxt = LEN_LO;
          w_code_nxt  = ERR_NONE;
        end
      end
      LEN_LO: begin
        if (w_accept) w_state_nxt = LEN_HI;
        else if (w_tmo_hit) begin
          w_state_nxt = ERR;
          w_code_nxt  = ERR_TIMEOUT;
        end
      end
      LEN_HI: begin
        if (w_accept) begin
          if (w_len_full > 17'(DEPTH)) begin
            w_state_nxt = ERR;
            w_code_nxt  = ERR_LEN;
          end else if (w_len_full == 17'd0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
            w_state_nxt = CHK;
`else
            w_state_nxt = DONE;
`endif
          end else begin
            w_state_nxt = DATA;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = ERR;
          w_code_nxt  = ERR_TIMEOUT;
        end
      end
      DATA: begin
        if (w_last_wr) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          // A byte taken during the final write cycle is already the checksum.
          if (w_accept) begin
            w_state_nxt = w_csum_ok ? DONE : ERR;
            w_code_nxt  = w_csum_ok ? ERR_NONE : ERR_CSUM;
          end else begin
            w_state_nxt = CHK;
          end
`else
          w_state_nxt = DONE;
`endif
        end else if (w_tmo_hit) begin
          w_state_nxt = ERR;
          w_code_nxt  = ERR_TIMEOUT;
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      CHK: begin
        if (w_accept) begin
          w_state_nxt = w_csum_ok ? DONE : ERR;
          w_code_nxt  = w_csum_ok ? ERR_NONE : ERR_CSUM;
        end else if (w_tmo_hit) begin
          w_state_nxt = ERR;
          w_code_nxt  = ERR_TIMEOUT;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    core_rst_n = 1'b0;
    case (r_state)
      LEN_LO, LEN_HI, DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      DONE: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_lo <= '0;
      r_len    <= '0;
      r_wcnt   <= '0;
      r_tmo    <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      r_sum    <= '0;
`endif
    end else if (w_start) begin
      r_wcnt <= '0;
      r_tmo  <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      r_sum  <= '0;
`endif
    end else begin
      if (w_accept) r_tmo <= '0;
      else if (rx_ready) r_tmo <= r_tmo + TW'(1);
      if (w_accept && r_state == LEN_LO) r_len_lo <= rx_data;
      if (w_accept && r_state == LEN_HI) r_len <= w_len_full[ADDR_W:0];
      // Index holds at the last word so a full-depth load never wraps.
      if (w_word_valid && !w_last_wr) r_wcnt <= r_wcnt + (ADDR_W+1)'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
      if (w_accept && (r_state == LEN_LO || r_state == LEN_HI || r_state == DATA))
        r_sum <= r_sum + rx_data;
`endif
    end
  end

  assign rom_we    = w_word_valid;
  assign rom_waddr = r_wcnt[ADDR_W-1:0];
  assign rom_wdata = w_word;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_rom_loader.sv
// Directed/random bench for rom_loader with a queue-based model of ROM writes.
module tb_rom_loader;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TMO   = 100;
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, rom_we, core_rst_n, busy, done, err;
  logic [AW-1:0] rom_waddr;
  logic [31:0]   rom_wdata;
  logic [1:0]    err_code;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] frame_words[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  rom_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rom_we     (rom_we),
    .rom_waddr  (rom_waddr),
    .rom_wdata  (rom_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every ROM write must match the next entry the model expects.
  always @(negedge clk) begin
    if (rst === 1'b0 && rom_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("waddr", 32'(rom_waddr), 32'(e.a));
        check("wdata", rom_wdata, e.d);
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_rom_we", 32'(rom_we), 32'd0);
    check("rst_waddr", 32'(rom_waddr), 32'd0);
    check("rst_wdata", rom_wdata, 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done_clr", 32'(done), 32'd0);
    check("start_err_clr", 32'(err), 32'd0);
    check("start_code_clr", 32'(err_code), 32'd0);
    check("start_core_held", 32'(core_rst_n), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    if (with_start) start = 1'b1;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic fill_random(input int n);
    frame_words.delete();
    repeat (n) frame_words.push_back($urandom);
  endtask

  task automatic push_words(input int n);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      w.a = AW'(i);
      w.d = frame_words[i];
      exp_q.push_back(w);
    end
  endtask

  task automatic run_frame(input int n, input int gapmax, input bit corrupt, input bit start_mid);
    logic [7:0]  bytes[$];
    logic [15:0] nn;
    logic [31:0] wd;
    logic [7:0]  sum;
    bit          exp_ok;
    int          exp_code;
    nn = n[15:0];
    bytes.push_back(nn[7:0]);
    bytes.push_back(nn[15:8]);
    if (n <= DEPTH) begin
      push_words(n);
      for (int i = 0; i < n; i++) begin
        wd = frame_words[i];
        for (int k = 0; k < 4; k++) bytes.push_back(wd[8*k +: 8]);
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      sum = 8'd0;
      foreach (bytes[i]) sum = sum + bytes[i];
      sum = 8'd0 - sum;
      if (corrupt) sum = sum ^ 8'h5A;
      bytes.push_back(sum);
`endif
    end
    start_pulse();
    foreach (bytes[i]) send_byte(bytes[i], $urandom_range(gapmax, 0), start_mid && i == 5);
    wait_idle();
    exp_ok   = (n <= DEPTH) && !(CSUM && corrupt);
    exp_code = (n > DEPTH) ? 2 : ((CSUM && corrupt) ? 3 : 0);
    check("frame_done", 32'(done), 32'(exp_ok));
    check("frame_err", 32'(err), 32'(!exp_ok));
    check("frame_code", 32'(err_code), 32'(exp_code));
    check("frame_core_rst_n", 32'(core_rst_n), 32'(exp_ok));
    check("frame_rom_we_idle", 32'(rom_we), 32'd0);
    check("frame_writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] wd;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1 check_reset_vals();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // Reference program frame
    frame_words.delete();
    frame_words.push_back(32'h0000_0013);
    frame_words.push_back(32'h0010_0093);
    run_frame(2, 0, 1'b0, 1'b0);

    // Empty frame, overflow, full-depth frame
    run_frame(0, 1, 1'b0, 1'b0);
    run_frame(17, 1, 1'b0, 1'b0);
    fill_random(16);
    run_frame(16, 2, 1'b0, 1'b0);

    // Timeout after five payload bytes of a two-word frame
    fill_random(2);
    push_words(1);
    start_pulse();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    wd = frame_words[0];
    for (int k = 0; k < 4; k++) send_byte(wd[8*k +: 8], 0, 1'b0);
    wd = frame_words[1];
    send_byte(wd[7:0], 0, 1'b0);
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("tmo_not_yet_err", 32'(err), 32'd0);
    check("tmo_not_yet_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_code", 32'(err_code), 32'd1);
    check("tmo_core_rst_n", 32'(core_rst_n), 32'd0);
    check("tmo_writes_left", 32'(exp_q.size()), 32'd0);

    // A byte landing on the timeout cycle keeps the frame alive
    fill_random(2);
    push_words(2);
    start_pulse();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    wd = frame_words[0];
    for (int k = 0; k < 4; k++) send_byte(wd[8*k +: 8], 0, 1'b0);
    wd = frame_words[1];
    send_byte(wd[7:0], 0, 1'b0);
    repeat (TMO - 1) @(posedge clk);
    for (int k = 1; k < 4; k++) send_byte(wd[8*k +: 8], 0, 1'b0);
`ifdef ROM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] s;
      s = 8'h02;
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 4; k++) s = s + frame_words[i][8*k +: 8];
      send_byte(8'd0 - s, 0, 1'b0);
    end
`endif
    wait_idle();
    check("late_byte_done", 32'(done), 32'd1);
    check("late_byte_err", 32'(err), 32'd0);
    check("late_byte_writes_left", 32'(exp_q.size()), 32'd0);

`ifdef ROM_LOADER_CHECKSUM_EN
    fill_random(1);
    run_frame(1, 1, 1'b1, 1'b0);
    fill_random(1);
    run_frame(1, 1, 1'b0, 1'b0);
`endif

    // Random frames with gaps; one has start pulsed while busy
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(DEPTH, 1);
      fill_random(n);
      run_frame(n, 3, 1'b0, r == 1);
    end

    // Asynchronous reset in the middle of DATA
    fill_random(4);
    push_words(1);
    start_pulse();
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      wd = frame_words[i / 4];
      send_byte(wd[8*(i % 4) +: 8], $urandom_range(2, 0), 1'b0);
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_writes_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    fill_random(3);
    run_frame(3, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
